// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side FIFO behind a uart receiver. Captures each byte and
//               its error flags, acknowledges with rdn, and presents entries
//               first-word-fall-through in the clk16x domain.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk16x,
    input  logic          clrn,
    input  logic          r_ready,
    input  logic [DW-1:0] d_rx,
    input  logic          parity_error,
    input  logic          frame_error,
    output logic          rdn,
    input  logic          rd,
    output logic [DW-1:0] q,
    output logic          q_perr,
    output logic          q_ferr,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          clr_ovr
);

    localparam int          C_DEPTH    = 2**AW;
    localparam logic [AW:0] C_FULL_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_rdn;
    logic          r_ovr;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [DW+1:0] r_mem [C_DEPTH];

    logic w_cap;
    logic w_wr;
    logic w_pop;
    logic w_empty;
    logic w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL_CNT);

    // Full is the pre-edge occupancy, so a simultaneous pop never frees room for the write.
    assign w_cap = (r_state == S_IDLE) && r_ready;
    assign w_wr  = w_cap && !w_full;
    assign w_pop = rd && !w_empty;

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_rdn   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_ready) begin
                        r_state <= S_ACK;
                        r_rdn   <= 1'b0;
                    end
                end
                S_ACK: begin
                    r_state <= S_WAIT;
                    r_rdn   <= 1'b1;
                end
                S_WAIT: begin
                    r_rdn <= 1'b1;
                    if (!r_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdn   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A discard in the same cycle as clr_ovr keeps the flag set.
    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            r_ovr <= 1'b0;
        end else if (w_cap && w_full) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk16x) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {frame_error, parity_error, d_rx};
        end
    end

    assign rdn     = r_rdn;
    assign q       = r_mem[r_rptr][DW-1:0];
    assign q_perr  = r_mem[r_rptr][DW];
    assign q_ferr  = r_mem[r_rptr][DW+1];
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign overrun = r_ovr;

endmodule
`default_nettype wire
